alu_pc_core: RTL and testbench
==============================

ALU_PC_CORE -- requirements
Module: alu_pc_core

Interface
- REQ-001: Parameter RESET_PC, default 32'h00400000, value loaded into pc on reset.
- REQ-002: clock  input  1  rising-edge clock for all state.
- REQ-003: reset  input  1  asynchronous, active-high reset.
- REQ-004: next_pc  input  32  PC value to load on the next rising clock edge.
- REQ-005: pc  output  32  current program counter, registered.
- REQ-006: aluop_in  input  4  ALU operation requested by main control.
- REQ-007: funct  input  6  instruction function field, bits [5:0].
- REQ-008: rtype  input  1  1 = decode funct; 0 = use aluop_in.
- REQ-009: shamt  input  5  shift amount, instruction bits [10:6].
- REQ-010: a  input  32  ALU operand A (rs data).
- REQ-011: b  input  32  ALU operand B (rt data or immediate).
- REQ-012: alu_ctrl  output  4  operation selected by the control stage.
- REQ-013: result  output  32  ALU result.
- REQ-014: zero  output  1  1 when result == 32'h0.

Function
- REQ-015: ALU op encodings SHALL be:
  - ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, NOR 1100.
  - SLT 0111, SLTU 1000, SLL 1001, SRL 1010, SRA 1011, LUI 1101.
- REQ-016: When rtype=0, alu_ctrl SHALL equal aluop_in unchanged.
- REQ-017: When rtype=1, alu_ctrl SHALL be decoded from funct as follows:
  - 0x20/0x21 -> ADD; 0x22/0x23 -> SUB.
  - 0x24 -> AND; 0x25 -> OR; 0x26 -> XOR; 0x27 -> NOR.
  - 0x2A -> SLT; 0x2B -> SLTU.
  - 0x00 -> SLL; 0x02 -> SRL; 0x03 -> SRA.
- REQ-018: When rtype=1 and funct is any other value, alu_ctrl SHALL be ADD.
- REQ-019: The control stage and the ALU SHALL be purely combinational, with zero-cycle latency from inputs to alu_ctrl, result and zero.
- REQ-020: ADD/SUB SHALL be a + b / a - b modulo 2^32; wrap-around is silent and no overflow output or trap exists.
- REQ-021: AND/OR/XOR/NOR SHALL be bitwise on a and b.
- REQ-022: SLT SHALL give 32'h1 if a < b as signed, else 32'h0.
- REQ-023: SLTU SHALL give 32'h1 if a < b as unsigned, else 32'h0.
- REQ-024: SLL/SRL SHALL shift b logically by shamt; SRA SHALL shift b arithmetically by shamt, replicating b[31]; shamt=0 yields b.
- REQ-025: LUI SHALL give {b[15:0], 16'h0}.
- REQ-026: Unassigned alu_ctrl codes (0100, 0101, 1110, 1111) SHALL give result 32'h0, and therefore zero=1.
- REQ-027: zero SHALL be derived from the final result for every operation.
- REQ-028: On every rising clock edge with reset low, pc SHALL load next_pc; no enable or stall exists.
- REQ-029: pc SHALL load any 32-bit value verbatim, with no alignment masking and no sequencing added inside this block.

Reset
- REQ-030: Asserting reset SHALL immediately set pc to RESET_PC, with no clock edge required.
- REQ-031: pc SHALL hold RESET_PC while reset is high, regardless of clock.
- REQ-032: After reset deasserts, the first rising edge SHALL load next_pc.
- REQ-033: Reset asserted between clock edges SHALL override any pending load.
- REQ-034: The ALU and the control stage have no state and SHALL be unaffected by reset.

Verification
- REQ-035: Reset pulse mid-cycle with next_pc=32'h00400004 -> pc=32'h00400000 at once; after release, first edge -> pc=32'h00400004, next edge with next_pc=32'h00400008 -> 32'h00400008.
- REQ-036: rtype=0, aluop_in=0010, a=32'hFFFFFFFF, b=1 -> result=0, zero=1 (wrap).
- REQ-037: rtype=1, funct=0x22, a=5, b=7 -> alu_ctrl=0110, result=32'hFFFFFFFE, zero=0.
- REQ-038: funct=0x2A with a=32'hFFFFFFFF, b=1 -> result=1; funct=0x2B with the same operands -> result=0.
- REQ-039: funct=0x03, shamt=4, b=32'h80000000 -> result=32'hF8000000; funct=0x02 with the same inputs -> 32'h08000000.
- REQ-040: rtype=1, funct=0x3F, a=3, b=4 -> alu_ctrl=0010, result=7; rtype=0, aluop_in=1101, b=32'h00001234 -> result=32'h12340000.

Source files
------------

// File: rtl/alu_pc_core_if.sv
// Bus bundle for alu_pc_core: PC load path plus ALU control/operand/result signals.
// master drives operands and next_pc; slave is the core.
interface alu_pc_core_if;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic [3:0]  aluop_in;
    logic [5:0]  funct;
    logic        rtype;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;

    modport master (
        output next_pc, aluop_in, funct, rtype, shamt, a, b,
        input  pc, alu_ctrl, result, zero
    );

    modport slave (
        input  next_pc, aluop_in, funct, rtype, shamt, a, b,
        output pc, alu_ctrl, result, zero
    );
endinterface

// File: rtl/alu_pc_core.sv
// Program counter register plus a combinational ALU control decoder and ALU.
// Only pc holds state; control and ALU paths ignore reset.
module alu_pc_core #(
    parameter logic [31:0] RESET_PC = 32'h00400000
) (
    input logic          clock,
    input logic          reset,
    alu_pc_core_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_LUI  = 4'b1101;

    logic [31:0] pc_q;
    logic [3:0]  ctrl;
    logic [31:0] res;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= bus.next_pc;
    end

    // Unknown R-type functs fall back to ADD rather than an illegal code.
    always_comb begin
        ctrl = bus.aluop_in;
        if (bus.rtype) begin
            case (bus.funct)
                6'h20, 6'h21: ctrl = OP_ADD;
                6'h22, 6'h23: ctrl = OP_SUB;
                6'h24:        ctrl = OP_AND;
                6'h25:        ctrl = OP_OR;
                6'h26:        ctrl = OP_XOR;
                6'h27:        ctrl = OP_NOR;
                6'h2A:        ctrl = OP_SLT;
                6'h2B:        ctrl = OP_SLTU;
                6'h00:        ctrl = OP_SLL;
                6'h02:        ctrl = OP_SRL;
                6'h03:        ctrl = OP_SRA;
                default:      ctrl = OP_ADD;
            endcase
        end
    end

    always_comb begin
        res = 32'h0;
        case (ctrl)
            OP_ADD:  res = bus.a + bus.b;
            OP_SUB:  res = bus.a - bus.b;
            OP_AND:  res = bus.a & bus.b;
            OP_OR:   res = bus.a | bus.b;
            OP_XOR:  res = bus.a ^ bus.b;
            OP_NOR:  res = ~(bus.a | bus.b);
            OP_SLT:  res = {31'h0, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU: res = {31'h0, bus.a < bus.b};
            OP_SLL:  res = bus.b << bus.shamt;
            OP_SRL:  res = bus.b >> bus.shamt;
            OP_SRA:  res = $unsigned($signed(bus.b) >>> bus.shamt);
            OP_LUI:  res = {bus.b[15:0], 16'h0};
            default: res = 32'h0;
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.alu_ctrl = ctrl;
    assign bus.result   = res;
    assign bus.zero     = (res == 32'h0);
endmodule

// File: tb/tb_alu_pc_core.sv
// Directed bench for alu_pc_core: async reset behaviour of pc, PC loading,
// and hand-computed ALU control/result/zero vectors.
module tb_alu_pc_core;
    logic clock;
    logic reset;
    int   errs;
    int   checks;

    alu_pc_core_if bus();

    alu_pc_core #(.RESET_PC(32'h00400000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic vec(input string tag, input logic rt, input logic [3:0] op,
                       input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [3:0] exp_ctrl, input logic [31:0] exp_res);
        bus.rtype    = rt;
        bus.aluop_in = op;
        bus.funct    = fn;
        bus.shamt    = sh;
        bus.a        = av;
        bus.b        = bv;
        #1;
        chk({tag, ".ctrl"}, {28'h0, bus.alu_ctrl}, {28'h0, exp_ctrl});
        chk({tag, ".res"},  bus.result, exp_res);
        chk({tag, ".zero"}, {31'h0, bus.zero}, {31'h0, exp_res == 32'h0});
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        reset  = 1'b1;
        bus.next_pc  = 32'h11110000;
        bus.rtype    = 1'b0;
        bus.aluop_in = 4'h0;
        bus.funct    = 6'h0;
        bus.shamt    = 5'h0;
        bus.a        = 32'h0;
        bus.b        = 32'h0;

        #2;
        chk("pc_reset", bus.pc, 32'h00400000);
        vec("alu_in_reset", 1'b1, 4'h0, 6'h20, 5'd0, 32'd1, 32'd2, 4'b0010, 32'd3);
        @(posedge clock); #1;
        chk("pc_hold_reset", bus.pc, 32'h00400000);

        @(negedge clock);
        reset = 1'b0;
        bus.next_pc = 32'h00400010;
        @(posedge clock); #1;
        chk("pc_load1", bus.pc, 32'h00400010);
        bus.next_pc = 32'hDEADBEEF;
        @(posedge clock); #1;
        chk("pc_unaligned", bus.pc, 32'hDEADBEEF);

        // Mid-cycle reset pulse overriding a pending load
        #2;
        bus.next_pc = 32'h00400004;
        reset = 1'b1;
        #1;
        chk("pc_async_rst", bus.pc, 32'h00400000);
        @(posedge clock); #1;
        chk("pc_rst_edge", bus.pc, 32'h00400000);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("pc_first_edge", bus.pc, 32'h00400004);
        bus.next_pc = 32'h00400008;
        @(posedge clock); #1;
        chk("pc_second_edge", bus.pc, 32'h00400008);

        @(negedge clock);
        vec("add_wrap",  1'b0, 4'b0010, 6'h22, 5'd0, 32'hFFFFFFFF, 32'd1, 4'b0010, 32'h0);
        vec("sub_f22",   1'b1, 4'b0000, 6'h22, 5'd0, 32'd5, 32'd7, 4'b0110, 32'hFFFFFFFE);
        vec("slt_neg",   1'b1, 4'b0000, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'd1, 4'b0111, 32'd1);
        vec("sltu_big",  1'b1, 4'b0000, 6'h2B, 5'd0, 32'hFFFFFFFF, 32'd1, 4'b1000, 32'd0);
        vec("slt_pos",   1'b1, 4'b0000, 6'h2A, 5'd0, 32'd1, 32'hFFFFFFFF, 4'b0111, 32'd0);
        vec("slt_min",   1'b1, 4'b0000, 6'h2A, 5'd0, 32'h80000000, 32'h7FFFFFFF, 4'b0111, 32'd1);
        vec("sltu_min",  1'b1, 4'b0000, 6'h2B, 5'd0, 32'h80000000, 32'h7FFFFFFF, 4'b1000, 32'd0);
        vec("sra_neg",   1'b1, 4'b0000, 6'h03, 5'd4, 32'h0, 32'h80000000, 4'b1011, 32'hF8000000);
        vec("srl",       1'b1, 4'b0000, 6'h02, 5'd4, 32'h0, 32'h80000000, 4'b1010, 32'h08000000);
        vec("sra_pos",   1'b1, 4'b0000, 6'h03, 5'd4, 32'h0, 32'h7FFFFFF0, 4'b1011, 32'h07FFFFFF);
        vec("sra_sh0",   1'b1, 4'b0000, 6'h03, 5'd0, 32'h0, 32'h80000001, 4'b1011, 32'h80000001);
        vec("sll",       1'b1, 4'b0000, 6'h00, 5'd8, 32'h5, 32'h00000081, 4'b1001, 32'h00008100);
        vec("sll_sh0",   1'b1, 4'b0000, 6'h00, 5'd0, 32'h5, 32'h12345678, 4'b1001, 32'h12345678);
        vec("dflt_f3f",  1'b1, 4'b0110, 6'h3F, 5'd0, 32'd3, 32'd4, 4'b0010, 32'd7);
        vec("lui",       1'b0, 4'b1101, 6'h00, 5'd0, 32'h0, 32'h00001234, 4'b1101, 32'h12340000);
        vec("and",       1'b1, 4'b0000, 6'h24, 5'd0, 32'hF0F000FF, 32'h0FF00F0F, 4'b0000, 32'h00F0000F);
        vec("or",        1'b1, 4'b0000, 6'h25, 5'd0, 32'hF0F000FF, 32'h0FF00F0F, 4'b0001, 32'hFFF00FFF);
        vec("xor",       1'b1, 4'b0000, 6'h26, 5'd0, 32'hF0F000FF, 32'h0FF00F0F, 4'b0011, 32'hFF000FF0);
        vec("nor",       1'b1, 4'b0000, 6'h27, 5'd0, 32'hF0F000FF, 32'h0FF00F0F, 4'b1100, 32'h000FF000);
        vec("addu_f21",  1'b1, 4'b0000, 6'h21, 5'd0, 32'd1, 32'd2, 4'b0010, 32'd3);
        vec("subu_f23",  1'b1, 4'b0000, 6'h23, 5'd0, 32'd10, 32'd3, 4'b0110, 32'd7);
        vec("sub_zero",  1'b0, 4'b0110, 6'h00, 5'd0, 32'd5, 32'd5, 4'b0110, 32'd0);
        vec("pass_op",   1'b0, 4'b0000, 6'h22, 5'd0, 32'hFF00FF00, 32'h0F0F0F0F, 4'b0000, 32'h0F000F00);
        vec("unasg_5",   1'b0, 4'b0101, 6'h00, 5'd0, 32'd5, 32'd5, 4'b0101, 32'd0);
        vec("unasg_f",   1'b0, 4'b1111, 6'h00, 5'd0, 32'hFFFFFFFF, 32'd1, 4'b1111, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
